// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the dmem_ctrl data-memory controller.
package dmem_pkg;

    // Access size encodings carried on req_size (2'd3 is illegal)
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Read data returned for accesses outside the RAM window
    localparam logic [31:0] OOB_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Where the registered response takes its read data from
    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_OOB  = 3'd1,
        SRC_ROM0 = 3'd2,
        SRC_ROM1 = 3'd3,
        SRC_RAM  = 3'd4
    } rsp_src_e;

    // Byte lanes touched by an access of the given size at byte offset addr_lo
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SZ_B:    mask = 4'b0001 << addr_lo;
            SZ_H:    mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Pick the addressed lane(s) out of a 32-bit word and extend to 32 bits
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] addr_lo, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = word[{addr_lo, 3'b000} +: 8];
        h   = addr_lo[1] ? word[31:16] : word[15:0];
        res = word;
        case (size)
            SZ_B:    res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word RAM with per-byte write enables and a registered,
// write-first read port (a same-cycle write to the read address is forwarded).
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read; read data only moves when re is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
            if (re) begin
                rdata_q[i*8 +: 8] <= we[i] ? wdata[i*8 +: 8] : mem[addr][i*8 +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response channels, fault decode,
// two read-only constant words, byte/half/word loads with extension.
// Optional build macro DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ROM_ADDR_0 = 32'hFFFF_FFF0,
    parameter logic [31:0] ROM_DATA_0 = 32'h5355_5259,
    parameter logic [31:0] ROM_ADDR_1 = 32'hFFFF_FFF4,
    parameter logic [31:0] ROM_DATA_1 = 32'h0053_4149,
    parameter logic [31:0] OOB_DATA   = OOB_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
`ifdef DMEM_STATS_EN
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errs,
`endif
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic        fire;
    logic [31:0] off;
    logic        in_range;
    logic        rom0_hit;
    logic        rom1_hit;
    logic        misaligned;
    logic        err_d;
    rsp_src_e    src_d;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    rsp_src_e    rsp_src_q, rsp_src_d;
    logic [1:0]  rsp_size_q, rsp_size_d;
    logic [1:0]  rsp_lo_q, rsp_lo_d;
    logic        rsp_uns_q, rsp_uns_d;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign fire      = req_valid && req_ready;

    // BASE_ADDR is window-aligned, so off[1:0] equals req_addr[1:0]
    assign off        = req_addr - BASE_ADDR;
    assign in_range   = (off[31:AW+2] == '0);
    assign rom0_hit   = (req_addr[31:2] == ROM_ADDR_0[31:2]);
    assign rom1_hit   = (req_addr[31:2] == ROM_ADDR_1[31:2]);
    assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                        ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));

    // Store data replicated across lanes; lane_mask picks which ones land
    assign ram_wdata = (req_size == SZ_B) ? {4{req_wdata[7:0]}} :
                       (req_size == SZ_H) ? {2{req_wdata[15:0]}} : req_wdata;

    // Prioritised fault decode and RAM port control for the current request
    always_comb begin
        err_d  = 1'b0;
        src_d  = SRC_ZERO;
        ram_we = 4'b0000;
        ram_re = 1'b0;
        if (req_size == 2'd3) begin
            err_d = 1'b1;
        end else if (misaligned) begin
            err_d = 1'b1;
        end else if (rom0_hit || rom1_hit) begin
            if (req_we) begin
                err_d = 1'b1;
            end else begin
                src_d = rom0_hit ? SRC_ROM0 : SRC_ROM1;
            end
        end else if (!in_range) begin
            err_d = 1'b1;
            src_d = SRC_OOB;
        end else if (req_we) begin
            ram_we = fire ? lane_mask(req_size, off[1:0]) : 4'b0000;
        end else begin
            ram_re = fire;
            src_d  = SRC_RAM;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (off[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Response register next-state: load on fire, retire on consumer accept
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_src_d   = rsp_src_q;
        rsp_size_d  = rsp_size_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_uns_d   = rsp_uns_q;
        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_d;
            rsp_src_d   = src_d;
            rsp_size_d  = req_size;
            rsp_lo_d    = off[1:0];
            rsp_uns_d   = req_unsigned;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register state; reset drops any pending response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_src_q   <= SRC_ZERO;
            rsp_size_q  <= SZ_B;
            rsp_lo_q    <= 2'b00;
            rsp_uns_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_src_q   <= rsp_src_d;
            rsp_size_q  <= rsp_size_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_uns_q   <= rsp_uns_d;
        end
    end

    // Read data is rebuilt from held state, so it stays stable under back-pressure
    always_comb begin
        rsp_rdata = 32'd0;
        case (rsp_src_q)
            SRC_OOB:  rsp_rdata = OOB_DATA;
            SRC_ROM0: rsp_rdata = load_extend(ROM_DATA_0, rsp_size_q, rsp_lo_q, rsp_uns_q);
            SRC_ROM1: rsp_rdata = load_extend(ROM_DATA_1, rsp_size_q, rsp_lo_q, rsp_uns_q);
            SRC_RAM:  rsp_rdata = load_extend(ram_rdata, rsp_size_q, rsp_lo_q, rsp_uns_q);
            default:  rsp_rdata = 32'd0;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads_q, stat_loads_d;
    logic [31:0] stat_stores_q, stat_stores_d;
    logic [31:0] stat_errs_q, stat_errs_d;

    // Saturating per-type counters bumped on every fired request
    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_errs_d   = stat_errs_q;
        if (fire) begin
            if (req_we && (stat_stores_q != 32'hFFFF_FFFF)) stat_stores_d = stat_stores_q + 32'd1;
            if (!req_we && (stat_loads_q != 32'hFFFF_FFFF)) stat_loads_d = stat_loads_q + 32'd1;
            if (err_d && (stat_errs_q != 32'hFFFF_FFFF))    stat_errs_d  = stat_errs_q + 32'd1;
        end
    end

    // Counter state, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_loads_q  <= 32'd0;
            stat_stores_q <= 32'd0;
            stat_errs_q   <= 32'd0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl with hand-computed expectations.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;
`endif

    int total;
    int bad;

    dmem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
`ifdef DMEM_STATS_EN
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_errs    (stat_errs),
`endif
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request that fires at the next edge; response checked 1 ns after that edge
    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        #1;
        chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        $display("xact %-12s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 tag, we, size, uns, addr, wdata, rsp_rdata, rsp_err);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        $display("reset released");

        // Word store / load and read-after-write on consecutive fires
        xact("sw4",   1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
        xact("lw4",   1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0);
        // Byte stores into each lane of word 0x8
        xact("sb8",   1'b1, 2'd0, 1'b0, 32'h0000_0008, 32'h0000_00FF, 32'h0000_0000, 1'b0);
        xact("sb9",   1'b1, 2'd0, 1'b0, 32'h0000_0009, 32'h0000_00FF, 32'h0000_0000, 1'b0);
        xact("sbA",   1'b1, 2'd0, 1'b0, 32'h0000_000A, 32'h1234_56FF, 32'h0000_0000, 1'b0);
        xact("sbB",   1'b1, 2'd0, 1'b0, 32'h0000_000B, 32'h0000_00FF, 32'h0000_0000, 1'b0);
        xact("lw8",   1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0,         32'hFFFF_FFFF, 1'b0);
        xact("lb9",   1'b0, 2'd0, 1'b0, 32'h0000_0009, 32'h0,         32'hFFFF_FFFF, 1'b0);
        xact("lbu9",  1'b0, 2'd0, 1'b1, 32'h0000_0009, 32'h0,         32'h0000_00FF, 1'b0);
        // Halfword extension and a byte overwrite inside word 0x4
        xact("lh6",   1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,         32'hFFFF_A5A5, 1'b0);
        xact("lhu6",  1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0,         32'h0000_A5A5, 1'b0);
        xact("sb5",   1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h0000_0012, 32'h0000_0000, 1'b0);
        xact("lw4b",  1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_12A5, 1'b0);
        xact("lb4",   1'b0, 2'd0, 1'b0, 32'h0000_0004, 32'h0,         32'hFFFF_FFA5, 1'b0);
        // Misalignment and illegal size
        xact("lh3",   1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0,         32'h0000_0000, 1'b1);
        xact("sw6",   1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'h1111_1111, 32'h0000_0000, 1'b1);
        xact("lw4c",  1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_12A5, 1'b0);
        xact("sz3",   1'b0, 2'd3, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b1);
        // Constant words
        xact("lwrom0", 1'b0, 2'd2, 1'b1, 32'hFFFF_FFF0, 32'h0,         32'h5355_5259, 1'b0);
        xact("swrom1", 1'b1, 2'd2, 1'b0, 32'hFFFF_FFF4, 32'h0BAD_0BAD, 32'h0000_0000, 1'b1);
        xact("lwrom1", 1'b0, 2'd2, 1'b0, 32'hFFFF_FFF4, 32'h0,         32'h0053_4149, 1'b0);
        xact("lbrom1", 1'b0, 2'd0, 1'b0, 32'hFFFF_FFF1, 32'h0,         32'h0000_0052, 1'b0);
        xact("lhrom2", 1'b0, 2'd1, 1'b0, 32'hFFFF_FFF2, 32'h0,         32'h0000_5355, 1'b0);
        // Range boundaries (DEPTH=1024 -> window 0x0000..0x0FFF)
        xact("oob",   1'b0, 2'd2, 1'b0, 32'hFFFF_FF00, 32'h0,         32'hDEAD_BEEF, 1'b1);
        xact("swtop", 1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0123_4567, 32'h0000_0000, 1'b0);
        xact("lwtop", 1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0123_4567, 1'b0);
        xact("lhtop", 1'b0, 2'd1, 1'b0, 32'h0000_0FFE, 32'h0,         32'h0000_0123, 1'b0);
        xact("lwend", 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 1'b1);

        // Back-pressure: LW 0x8 fires, then the consumer stalls for 3 cycles
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0008;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_addr  = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp.rdata", rsp_rdata, 32'hFFFF_FFFF);
            chk("bp.err", {31'd0, rsp_err}, 32'd0);
            $display("stall cycle %0d rdata=%h req_ready=%0d", i, rsp_rdata, req_ready);
            @(posedge clk);
            #1;
        end
        #1;
        chk("bp.stable", rsp_rdata, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        #1;
        chk("bp.release", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp.next", rsp_rdata, 32'hA5A5_12A5);
        $display("stall released, next rdata=%h", rsp_rdata);

        // Reset with a response pending
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        chk("rstp.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstp.rdata", rsp_rdata, 32'd0);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("rstp.req_ready", {31'd0, req_ready}, 32'd1);
        $display("reset with pending response done");
        xact("lw4post", 1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_12A5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the core's flat data memory.
- Valid/ready request and response channels; 1-cycle registered read latency; back-pressure; LB/LH/LW loads with zero- or sign-extension.
- Detects misaligned and out-of-range accesses; maps two read-only constant words.
- Sits between the load/store unit and the word-organised RAM array.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
- ROM_ADDR_0, 32'hFFFF_FFF0, word-aligned byte address of constant word 0.
- ROM_DATA_0, 32'h5355_5259, value returned at ROM_ADDR_0.
- ROM_ADDR_1, 32'hFFFF_FFF4, word-aligned byte address of constant word 1.
- ROM_DATA_1, 32'h0053_4149, value returned at ROM_ADDR_1.
- OOB_DATA, 32'hDEAD_BEEF, read data on out-of-range access.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (LSBs).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, extended; 0 for stores.
- rsp_err  out  1  access fault (misaligned, out-of-range, ROM write, or size 3).

Behaviour:
- Reset (rst_n=0 at posedge):
  - rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 on the following cycle.
  - RAM contents are not cleared.
  - A response pending at reset is dropped.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (combinational).
  - Request fires when req_valid && req_ready.
  - Every fired request produces exactly one response, visible the next cycle.
  - rsp_* stay stable while rsp_valid && !rsp_ready.
  - Back-to-back fire every cycle when rsp_ready is held at 1.
- Fault decode, priority order:
  - size 3 → err.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) → err.
  - addr equals ROM_ADDR_0/1: loads OK; stores → err, no write.
  - addr outside [BASE_ADDR, BASE_ADDR+DEPTH*4) → err, rsp_rdata=OOB_DATA.
  - Any other faulted access → rsp_rdata=0.
  - Faulted stores never modify RAM.
- Stores:
  - Byte-lane enables derived from size and addr[1:0].
  - wdata is replicated to the selected lanes.
  - RAM is written on the fire edge.
- Loads:
  - RAM read on the fire edge.
  - Lane extract by addr[1:0], then zero/sign-extend.
  - ROM word load ignores req_unsigned (word size).
  - Sub-word ROM loads are allowed and are extracted/extended like RAM.
- Read-after-write to the same word on consecutive fires returns the new data; write-first semantics are required.
- Word index = (addr - BASE_ADDR) >> 2, using log2(DEPTH) bits.

Optional Feature:
- Macro DMEM_STATS_EN.
- When defined, adds outputs stat_loads, stat_stores, stat_errs (32-bit each).
- Counters increment on fire by type; err counts faulted accesses, which are also counted in loads/stores.
- Counters saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W.
  - function lane_mask(size, addr_lo) → 4-bit byte-lane mask.
  - function load_extend(word, size, addr_lo, unsigned) → 32-bit result.
  - default OOB_DATA.
- Sub-module dmem_array: DEPTH×32 RAM with 4 byte write-enables and a synchronous read port, write-first.
- dmem_ctrl owns decode, fault logic and the response register.

Test Plan:
- Store word 32'hA5A5_A5A5 @0x4, then load word @0x4 → rsp_rdata=A5A5_A5A5, err=0.
- Four byte stores of 0xFF to lanes 0..3 @0x8, then LW → FFFF_FFFF; LB @0x9 signed → FFFF_FFFF; LBU → 0000_00FF.
- LH @0x3 → err=1, rdata=0; SW @0x6 → err=1, and a following LW @0x4 is unchanged.
- LW @ROM_ADDR_0 → 5355_5259; SW @ROM_ADDR_1 → err=1; then LW @ROM_ADDR_1 → 0053_4149.
- LW @0xFFFF_FF00 → err=1, rdata=DEAD_BEEF.
- Hold rsp_ready=0 for 3 cycles during a load → req_ready=0 and rsp_* stable. Assert rst_n=0 with a response pending → next cycle rsp_valid=0.
